// File: rtl/ex_div_seq_if.sv
// Handshake bundle between the execute stage and the sequential divider.
// The pipeline side uses the master modport; the divider uses the slave modport.
interface ex_div_seq_if;
    logic        div_start;
    logic [1:0]  div_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        mem_hold;
    logic        dbg;
    logic        ex_hold;
    logic        div_done;
    logic [31:0] div_res;
    logic        busy;

    modport master (
        output div_start, div_op, op_a, op_b, flush, mem_hold, dbg,
        input  ex_hold, div_done, div_res, busy
    );

    modport slave (
        input  div_start, div_op, op_a, op_b, flush, mem_hold, dbg,
        output ex_hold, div_done, div_res, busy
    );
endinterface

// File: rtl/ex_div_seq.sv
// Multi-cycle restoring divider for the execute stage (DIV/DIVU/REM/REMU).
// 32 iteration cycles plus a sign-fix cycle; divide-by-zero and overflow finish in one cycle.
module ex_div_seq (
    input  logic        clk,
    input  logic        Rst,
    ex_div_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t      state_r, state_s;
    logic [4:0]  count_r, count_s;
    logic [31:0] rem_r, rem_s;
    logic [31:0] quo_r, quo_s;
    logic [31:0] b_r, b_s;
    logic [31:0] res_r, res_s;
    logic [1:0]  op_r, op_s;
    logic        sign_a_r, sign_a_s;
    logic        sign_b_r, sign_b_s;
    logic        done_r;
    logic        busy_r;

    logic        start_s;
    logic        signed_op_s;
    logic        div_zero_s;
    logic        overflow_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [32:0] shifted_s;
    logic [32:0] trial_s;
    logic [31:0] q_fix_s;
    logic [31:0] r_fix_s;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Operand decode, one restoring step and the final sign correction.
    always_comb begin
        start_s     = bus.div_start && !bus.flush;
        signed_op_s = !bus.div_op[0];
        div_zero_s  = (bus.op_b == 32'd0);
        overflow_s  = signed_op_s && (bus.op_a == 32'h8000_0000) && (bus.op_b == 32'hFFFF_FFFF);
        abs_a_s     = (signed_op_s && bus.op_a[31]) ? neg32(bus.op_a) : bus.op_a;
        abs_b_s     = (signed_op_s && bus.op_b[31]) ? neg32(bus.op_b) : bus.op_b;
        // Partial remainder is below the divisor, so the 33-bit shifted value never overflows.
        shifted_s   = {rem_r, quo_r[31]};
        trial_s     = shifted_s - {1'b0, b_r};
        q_fix_s     = (!op_r[0] && (sign_a_r != sign_b_r)) ? neg32(quo_r) : quo_r;
        r_fix_s     = (!op_r[0] && sign_a_r) ? neg32(rem_r) : rem_r;
    end

    // Next-state and datapath update; flush overrides every transition.
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        rem_s    = rem_r;
        quo_s    = quo_r;
        b_s      = b_r;
        op_s     = op_r;
        sign_a_s = sign_a_r;
        sign_b_s = sign_b_r;
        res_s    = 32'd0;
        if (bus.flush) begin
            state_s = IDLE;
            count_s = 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.div_start) begin
                        op_s     = bus.div_op;
                        sign_a_s = signed_op_s && bus.op_a[31];
                        sign_b_s = signed_op_s && bus.op_b[31];
                        count_s  = 5'd0;
                        if (div_zero_s) begin
                            state_s = DONE;
                            res_s   = bus.div_op[1] ? bus.op_a : 32'hFFFF_FFFF;
                        end else if (overflow_s) begin
                            state_s = DONE;
                            res_s   = bus.div_op[1] ? 32'd0 : 32'h8000_0000;
                        end else begin
                            state_s = BUSY;
                            rem_s   = 32'd0;
                            quo_s   = abs_a_s;
                            b_s     = abs_b_s;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                BUSY: begin
                    rem_s = trial_s[32] ? shifted_s[31:0] : trial_s[31:0];
                    quo_s = {quo_r[30:0], ~trial_s[32]};
                    if (count_r == 5'd31) begin
                        state_s = FIX;
                        count_s = 5'd0;
                    end else begin
                        state_s = BUSY;
                        count_s = count_r + 5'd1;
                    end
                end
                FIX: begin
                    state_s = DONE;
                    res_s   = op_r[1] ? r_fix_s : q_fix_s;
                end
                DONE: begin
                    if (!bus.mem_hold && !bus.dbg) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DONE;
                        res_s   = res_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                    count_s = 5'd0;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Iteration datapath registers.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            count_r  <= 5'd0;
            rem_r    <= 32'd0;
            quo_r    <= 32'd0;
            b_r      <= 32'd0;
            op_r     <= 2'b00;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
        end else begin
            count_r  <= count_s;
            rem_r    <= rem_s;
            quo_r    <= quo_s;
            b_r      <= b_s;
            op_r     <= op_s;
            sign_a_r <= sign_a_s;
            sign_b_r <= sign_b_s;
        end
    end

    // Registered outputs; res_s is zero unless the next state is DONE.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            res_r  <= 32'd0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            res_r  <= res_s;
            done_r <= (state_s == DONE);
            busy_r <= (state_s != IDLE);
        end
    end

    // Stall request must be combinational so the start cycle itself is held.
    assign bus.ex_hold  = !Rst && (((state_r == IDLE) && start_s) ||
                                   (state_r == BUSY) || (state_r == FIX));
    assign bus.div_done = done_r;
    assign bus.div_res  = res_r;
    assign bus.busy     = busy_r;

endmodule
